// File: rtl/ccip_avmm_pkg.sv
// Shared types and CSR map for the CCI-P MMIO Avalon-MM CSR block.
package ccip_avmm_pkg;

  localparam int unsigned CCIP_AVMM_MMIO_ADDR_WIDTH = 16;
  localparam int unsigned CSR_DATA_W                = 64;
  localparam int unsigned CSR_BE_W                  = 8;

  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_DFH          = 16'h0000;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_AFU_ID_L     = 16'h0008;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_AFU_ID_H     = 16'h0010;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_RSVD         = 16'h0018;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_CTRL         = 16'h0020;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_STATUS       = 16'h0028;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_ERR          = 16'h0030;
  localparam logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] CSR_SCRATCH_BASE = 16'h0100;

  typedef enum logic [0:0] {
    CSR_INIT = 1'b0,
    CSR_IDLE = 1'b1
  } t_csr_state;

  typedef struct packed {
    logic                  valid;
    logic [CSR_DATA_W-1:0] data;
  } t_csr_rd_rsp;

  // Replace only the byte lanes selected by be.
  function automatic logic [CSR_DATA_W-1:0] csr_be_merge(
    input logic [CSR_DATA_W-1:0] old_v,
    input logic [CSR_DATA_W-1:0] new_v,
    input logic [CSR_BE_W-1:0]   be
  );
    logic [CSR_DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(CSR_BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ccip_avmm_mmio_csr_rdpipe.sv
// Fixed-latency read response pipeline; reset clears every stage.
module ccip_avmm_mmio_csr_rdpipe
  import ccip_avmm_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  t_csr_rd_rsp rsp_i,
  output t_csr_rd_rsp rsp_o
);

  t_csr_rd_rsp pipe_q [LATENCY];
  t_csr_rd_rsp pipe_d [LATENCY];

  always_comb begin
    pipe_d[0] = rsp_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign rsp_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/ccip_avmm_mmio_csr.sv
// Avalon-MM CSR slave for the CCI-P MMIO bridge: DFH/ID, CTRL/STATUS, scratch, clear-on-init FSM.
// Optional error capture register enabled by defining CCIP_AVMM_MMIO_CSR_ERR_EN.
module ccip_avmm_mmio_csr
  import ccip_avmm_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_0000_0000,
  parameter int unsigned NUM_SCRATCH  = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avmm_address,
  input  logic                                 avmm_read,
  input  logic                                 avmm_write,
  input  logic [CSR_DATA_W-1:0]                avmm_writedata,
  input  logic [CSR_BE_W-1:0]                  avmm_byteenable,
  output logic                                 avmm_waitrequest,
  output logic [CSR_DATA_W-1:0]                avmm_readdata,
  output logic                                 avmm_readdatavalid
);

  localparam int unsigned AW    = CCIP_AVMM_MMIO_ADDR_WIDTH;
  localparam int unsigned WA_W  = AW - 3;
  localparam int unsigned IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  localparam logic [WA_W-1:0]  DFH_W      = CSR_DFH[AW-1:3];
  localparam logic [WA_W-1:0]  IDL_W      = CSR_AFU_ID_L[AW-1:3];
  localparam logic [WA_W-1:0]  IDH_W      = CSR_AFU_ID_H[AW-1:3];
  localparam logic [WA_W-1:0]  RSVD_W     = CSR_RSVD[AW-1:3];
  localparam logic [WA_W-1:0]  CTRL_W     = CSR_CTRL[AW-1:3];
  localparam logic [WA_W-1:0]  STATUS_W   = CSR_STATUS[AW-1:3];
  localparam logic [WA_W-1:0]  ERR_W      = CSR_ERR[AW-1:3];
  localparam logic [WA_W-1:0]  SCR_BASE_W = CSR_SCRATCH_BASE[AW-1:3];
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SCRATCH - 1);

  t_csr_state       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             waitrequest_q, waitrequest_d;
  logic [31:0]      rd_cnt_q, rd_cnt_d;
  logic [31:0]      wr_cnt_q, wr_cnt_d;
  logic [63:0]      scratch_q [NUM_SCRATCH];
  logic [63:0]      scratch_d [NUM_SCRATCH];

  logic [WA_W-1:0]  waddr, soff;
  logic [IDX_W-1:0] sidx;
  logic             hit_scr, hit_ro, hit_ctrl, hit_err, mapped;
  logic             rd_acc, wr_acc, coll, soft_init;
  logic [63:0]      rd_data, err_rd;
  t_csr_rd_rsp      rsp_in, rsp_out;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^avmm_address[2:0];

  // Address decode on the 8-byte word address.
  always_comb begin
    waddr    = avmm_address[AW-1:3];
    soff     = waddr - SCR_BASE_W;
    sidx     = soff[IDX_W-1:0];
    hit_scr  = (waddr >= SCR_BASE_W) && (soff < WA_W'(NUM_SCRATCH));
    hit_ro   = (waddr == DFH_W) || (waddr == IDL_W) || (waddr == IDH_W) ||
               (waddr == RSVD_W) || (waddr == STATUS_W);
    hit_ctrl = (waddr == CTRL_W);
    hit_err  = (waddr == ERR_W);
    mapped   = hit_scr || hit_ro || hit_ctrl || hit_err;
  end

  // A simultaneous read and write services only the read.
  always_comb begin
    rd_acc    = avmm_read & ~waitrequest_q;
    wr_acc    = avmm_write & ~avmm_read & ~waitrequest_q;
    coll      = avmm_write & avmm_read & ~waitrequest_q;
    soft_init = wr_acc & hit_ctrl & avmm_byteenable[0] & avmm_writedata[0];
  end

  always_comb begin
    rd_data = '0;
    if (hit_scr) begin
      rd_data = scratch_q[sidx];
    end else begin
      case (waddr)
        DFH_W:    rd_data = DFH_VALUE;
        IDL_W:    rd_data = AFU_ID_L;
        IDH_W:    rd_data = AFU_ID_H;
        STATUS_W: rd_data = {rd_cnt_q, wr_cnt_q};
        ERR_W:    rd_data = err_rd;
        default:  rd_data = '0;
      endcase
    end
  end

  // Scratch clear FSM; waitrequest follows the next state so it is registered.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CSR_INIT: begin
        if (clr_idx_q == IDX_LAST) begin
          state_d   = CSR_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      CSR_IDLE: begin
        if (soft_init) begin
          state_d   = CSR_INIT;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CSR_INIT;
        clr_idx_d = '0;
      end
    endcase
    waitrequest_d = (state_d == CSR_INIT);
  end

  always_comb begin
    scratch_d = scratch_q;
    if (state_q == CSR_INIT) begin
      scratch_d[clr_idx_q] = '0;
    end else if (wr_acc && hit_scr) begin
      scratch_d[sidx] = csr_be_merge(scratch_q[sidx], avmm_writedata, avmm_byteenable);
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q + (rd_acc ? 32'd1 : 32'd0);
    wr_cnt_d = wr_cnt_q + (wr_acc ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CSR_INIT;
      clr_idx_q     <= '0;
      waitrequest_q <= 1'b1;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      waitrequest_q <= waitrequest_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  // Scratch content is defined by the clear FSM that always runs out of reset.
  always_ff @(posedge clk) begin
    scratch_q <= scratch_d;
  end

`ifdef CCIP_AVMM_MMIO_CSR_ERR_EN
  logic [63:0] err_q, err_d;
  logic        err_evt;

  always_comb begin
    err_evt = coll | ((rd_acc | wr_acc) & ~mapped) | (wr_acc & hit_ro);
    err_d   = err_q;
    if (wr_acc && hit_err && avmm_byteenable[7] && avmm_writedata[63]) begin
      err_d = '0;
    end else if (err_evt && !err_q[63]) begin
      err_d = {1'b1, coll, 46'b0, 16'(avmm_address)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_rd = err_q;
`else
  assign err_rd = '0;
`endif

  // Data is captured at acceptance so later writes cannot disturb it.
  always_comb begin
    rsp_in.valid = rd_acc;
    rsp_in.data  = rd_acc ? rd_data : '0;
  end

  ccip_avmm_mmio_csr_rdpipe #(
    .LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clk     (clk),
    .reset_n (reset_n),
    .rsp_i   (rsp_in),
    .rsp_o   (rsp_out)
  );

  assign avmm_waitrequest   = waitrequest_q;
  assign avmm_readdata      = rsp_out.data;
  assign avmm_readdatavalid = rsp_out.valid;

endmodule
